// File: rtl/sdram_init_seq.sv
// SDR SDRAM power-up / re-init sequencer: wait, precharge-all, N_REF auto-refreshes,
// load mode register, then hands the bus to the controller. START re-runs it without the wait.
module sdram_init_seq #(
  parameter int CLK_MHZ      = 32,
  parameter int T_INIT_US    = 200,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 8,
  parameter int T_MRD        = 2,
  parameter int N_REF        = 8,
  parameter int CAS_LAT      = 2,
  parameter int BURST_LEN    = 1,
  parameter int BURST_TYPE   = 0,
  parameter int WRITE_SINGLE = 0,
  parameter int ADDR_W       = 13,
  parameter int BA_W         = 2,
  parameter int DQM_W        = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  output logic              sdr_CKE,
  output logic [3:0]        sdr_n_CS_WE_RAS_CAS,
  output logic [BA_W-1:0]   sdr_BA,
  output logic [ADDR_W-1:0] sdr_ADDR,
  output logic [DQM_W-1:0]  sdr_DQM,
  output logic              init_busy,
  output logic              init_done
);

  localparam int W       = CLK_MHZ * T_INIT_US;
  localparam int MAX_A   = (W > T_RFC) ? W : T_RFC;
  localparam int MAX_B   = (T_MRD > T_RP) ? T_MRD : T_RP;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int REF_W   = $clog2(N_REF + 1);

  localparam logic [3:0] CMD_INHIBIT = 4'b1111;
  localparam logic [3:0] CMD_NOP     = 4'b0111;
  localparam logic [3:0] CMD_PRE     = 4'b0001;
  localparam logic [3:0] CMD_REF     = 4'b0100;
  localparam logic [3:0] CMD_LMR     = 4'b0000;

  function automatic logic [2:0] bl_code(input int bl);
    case (bl)
      1:       return 3'b000;
      2:       return 3'b001;
      4:       return 3'b010;
      8:       return 3'b011;
      0:       return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  localparam logic [2:0] CAS_BITS = CAS_LAT[2:0];
  localparam logic [9:0] MR_BITS  = {WRITE_SINGLE[0], 2'b00, CAS_BITS, BURST_TYPE[0],
                                     bl_code(BURST_LEN)};
  localparam logic [ADDR_W-1:0] MODE_WORD = {{(ADDR_W-10){1'b0}}, MR_BITS};
  localparam logic [ADDR_W-1:0] PRE_ALL   = ADDR_W'(1) << 10;

  typedef enum logic [2:0] {S_WAIT, S_PRE, S_REF, S_MRS, S_DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [REF_W-1:0]   ref_cnt, ref_n;
  logic [3:0]         cmd_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [DQM_W-1:0]   dqm_n;
  logic               busy_n, done_n;

  // cnt counts cycles since the last command; a command state entered with cnt=0
  // issues its command on the following edge (used by the wait and by START).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ref_n   = ref_cnt;
    cmd_n   = CMD_NOP;
    addr_n  = '0;
    dqm_n   = '1;
    busy_n  = 1'b1;
    done_n  = 1'b0;
    case (state)
      S_WAIT: begin
        if (cnt == CNT_W'(W - 1)) begin
          state_n = S_PRE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_PRE: begin
        if (cnt == '0) begin
          cmd_n  = CMD_PRE;
          addr_n = PRE_ALL;
          cnt_n  = CNT_W'(1);
        end else if (cnt == CNT_W'(T_RP)) begin
          cmd_n   = CMD_REF;
          state_n = S_REF;
          cnt_n   = CNT_W'(1);
          ref_n   = REF_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_REF: begin
        if (cnt == CNT_W'(T_RFC)) begin
          cnt_n = CNT_W'(1);
          if (ref_cnt == REF_W'(N_REF)) begin
            cmd_n   = CMD_LMR;
            addr_n  = MODE_WORD;
            state_n = S_MRS;
          end else begin
            cmd_n = CMD_REF;
            ref_n = ref_cnt + REF_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_MRS: begin
        if (cnt == CNT_W'(T_MRD)) begin
          state_n = S_DONE;
          dqm_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (START) begin
          state_n = S_PRE;
          cnt_n   = '0;
        end else begin
          dqm_n  = '0;
          busy_n = 1'b0;
          done_n = 1'b1;
        end
      end
      default: state_n = S_WAIT;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state               <= S_WAIT;
      cnt                 <= '0;
      ref_cnt             <= '0;
      sdr_CKE             <= 1'b0;
      sdr_n_CS_WE_RAS_CAS <= CMD_INHIBIT;
      sdr_BA              <= '0;
      sdr_ADDR            <= '0;
      sdr_DQM             <= '1;
      init_busy           <= 1'b1;
      init_done           <= 1'b0;
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      ref_cnt             <= ref_n;
      sdr_CKE             <= 1'b1;
      sdr_n_CS_WE_RAS_CAS <= cmd_n;
      sdr_BA              <= '0;
      sdr_ADDR            <= addr_n;
      sdr_DQM             <= dqm_n;
      init_busy           <= busy_n;
      init_done           <= done_n;
    end
  end

endmodule
